// File: rtl/delta_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : delta_scan_ctrl
// Purpose  : Shares one delta-modulation compare datapath across NCH sample
//            channels. Each channel keeps a current sample and a reference
//            (previous spiking) value. A scan request walks every channel once,
//            in order, and gives one registered result per channel. A spiking
//            channel takes its compared sample as its new reference.
// Ports    : clk, rst_n (sync, active-low), ena (global stall when low)
//            sample_valid/sample_ch/sample_data : per-channel sample write
//            threshold, off_spike_en            : compare controls
//            scan_start -> busy                 : scan request / in progress
//            spike_valid, spike_ch, spike[1:0]  : per-channel result
//            scan_done                          : pulse with last result
// Config   : DELTA_REFRACTORY_EN - after a spike, a channel's next REFRAC
//            evaluations give no spike and leave the reference unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module delta_scan_ctrl #(
  parameter int NCH    = 4,
  parameter int DW     = 5,
  parameter int CW     = 2,
  parameter int REFRAC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          sample_valid,
  input  logic [CW-1:0] sample_ch,
  input  logic [DW-1:0] sample_data,
  input  logic [DW-1:0] threshold,
  input  logic          off_spike_en,
  input  logic          scan_start,
  output logic          busy,
  output logic          spike_valid,
  output logic [CW-1:0] spike_ch,
  output logic [1:0]    spike,
  output logic          scan_done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EVAL = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   data_q [NCH];
  logic [DW-1:0]   prev_q [NCH];

  logic            spike_valid_q;
  logic [CW-1:0]   spike_ch_q;
  logic [1:0]      spike_q;
  logic            scan_done_q;

  logic            w_eval;
  logic [DW-1:0]   w_cur_data;
  logic [DW-1:0]   w_cur_prev;
  logic signed [DW:0] w_diff;
  logic signed [DW:0] w_thr;
  logic            w_up_raw;
  logic            w_down_raw;
  logic            w_block;
  logic            w_hit;
  logic            w_down;

  // A channel is evaluated on every enabled edge spent in EVAL.
  assign w_eval     = ena && (state_q == S_EVAL);
  assign w_cur_data = data_q[idx_q];
  assign w_cur_prev = prev_q[idx_q];

  // Both operands are zero-extended, so the DW+1 bit signed difference
  // covers the full -(2^DW-1)..(2^DW-1) range without overflow.
  assign w_diff     = $signed({1'b0, w_cur_data}) - $signed({1'b0, w_cur_prev});
  assign w_thr      = $signed({1'b0, threshold});
  assign w_up_raw   = (w_diff > w_thr);
  assign w_down_raw = off_spike_en && (w_diff < -w_thr);

`ifdef DELTA_REFRACTORY_EN
  localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  logic [RW-1:0] ref_cnt_q [NCH];

  assign w_block = (ref_cnt_q[idx_q] != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) ref_cnt_q[i] <= '0;
    end else if (w_eval) begin
      if (w_block)
        ref_cnt_q[idx_q] <= ref_cnt_q[idx_q] - RW'(1);
      else if (w_hit)
        ref_cnt_q[idx_q] <= RW'(REFRAC);
    end
  end
`else
  logic w_unused_refrac;
  assign w_unused_refrac = ^REFRAC;
  assign w_block         = 1'b0;
`endif

  assign w_hit  = (w_up_raw || w_down_raw) && !w_block;
  assign w_down = w_down_raw && !w_block;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (scan_start) begin
            state_d = S_EVAL;
            idx_d   = '0;
          end
        end
        S_EVAL: begin
          idx_d = idx_q + CW'(1);
          if (idx_q == CW'(NCH - 1)) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // ------------------------------------------------ sample / reference
  // Reads above see the pre-edge data, so a write that collides with the
  // channel under evaluation only affects the next scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        data_q[i] <= '0;
        prev_q[i] <= '0;
      end
    end else if (ena) begin
      if (sample_valid) data_q[sample_ch] <= sample_data;
      if (w_eval && w_hit) prev_q[idx_q] <= w_cur_data;
    end
  end

  // ------------------------------------------------------- result regs
  // Valid/done are single-cycle pulses: any edge that does not evaluate
  // clears them, so a result masked by a stall is never replayed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_valid_q <= 1'b0;
      spike_ch_q    <= '0;
      spike_q       <= 2'b00;
      scan_done_q   <= 1'b0;
    end else if (w_eval) begin
      spike_valid_q <= w_hit;
      spike_ch_q    <= idx_q;
      spike_q       <= {w_down, w_hit};
      scan_done_q   <= (idx_q == CW'(NCH - 1));
    end else begin
      spike_valid_q <= 1'b0;
      scan_done_q   <= 1'b0;
    end
  end

  assign busy        = (state_q == S_EVAL);
  assign spike_valid = spike_valid_q && ena;
  assign scan_done   = scan_done_q && ena;
  assign spike_ch    = spike_ch_q;
  assign spike       = spike_q;

endmodule
`default_nettype wire

// File: tb/tb_delta_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_delta_scan_ctrl
// Purpose  : Directed self-checking bench for delta_scan_ctrl (NCH=4, DW=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_delta_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       sample_valid = 1'b0;
  logic [1:0] sample_ch = '0;
  logic [4:0] sample_data = '0;
  logic [4:0] threshold = 5'd3;
  logic       off_spike_en = 1'b0;
  logic       scan_start = 1'b0;
  logic       busy;
  logic       spike_valid;
  logic [1:0] spike_ch;
  logic [1:0] spike;
  logic       scan_done;

  int total = 0;
  int bad   = 0;

  logic       res_v    [4];
  logic [1:0] res_ch   [4];
  logic [1:0] res_sp   [4];
  logic       res_done [4];
  logic       res_busy0;
  logic       res_busy_end;

  delta_scan_ctrl #(.NCH(4), .DW(5), .CW(2), .REFRAC(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .threshold    (threshold),
    .off_spike_en (off_spike_en),
    .scan_start   (scan_start),
    .busy         (busy),
    .spike_valid  (spike_valid),
    .spike_ch     (spike_ch),
    .spike        (spike),
    .scan_done    (scan_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic write_ch(input logic [1:0] ch, input logic [4:0] d);
    sample_valid = 1'b1;
    sample_ch    = ch;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
  endtask

  // One full scan: edge E0 takes the request, edges E1..E4 give results.
  task automatic run_scan();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    res_busy0 = busy;
    for (int k = 0; k < 4; k++) begin
      tick();
      res_v[k]    = spike_valid;
      res_ch[k]   = spike_ch;
      res_sp[k]   = spike;
      res_done[k] = scan_done;
    end
    res_busy_end = busy;
  endtask

  // Lets refractory counters drain between deliberate spikes on one channel.
  task automatic settle();
`ifdef DELTA_REFRACTORY_EN
    run_scan();
    run_scan();
`endif
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({busy, spike_valid, scan_done, spike_ch, spike} !== 7'b0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b sv=%b done=%b ch=%0d sp=%b, want all 0",
               busy, spike_valid, scan_done, spike_ch, spike);
    end
    write_ch(2'd0, 5'd10);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    tick();
    do_reset();
    total++;
    if ({busy, spike_valid, scan_done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_midscan: got busy=%b sv=%b done=%b, want 000",
               busy, spike_valid, scan_done);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({busy, spike_valid, scan_done} !== 3'b000) begin
        bad++;
        $display("FAIL reset_no_results cyc%0d: got busy=%b sv=%b done=%b, want 000",
                 i, busy, spike_valid, scan_done);
      end
    end
    run_scan();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (res_v[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_zero_scan ch%0d: got sv=%b, want 0", k, res_v[k]);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    threshold = 5'd3;
    off_spike_en = 1'b0;
    write_ch(2'd0, 5'd10);
    run_scan();
    total++;
    if (res_v[0] !== 1'b1 || res_ch[0] !== 2'd0 || res_sp[0] !== 2'b01) begin
      bad++;
      $display("FAIL basic_ch0: got sv=%b ch=%0d sp=%b, want 1 0 01",
               res_v[0], res_ch[0], res_sp[0]);
    end
    for (int k = 1; k < 4; k++) begin
      total++;
      if (res_v[k] !== 1'b0 || res_ch[k] !== 2'(k)) begin
        bad++;
        $display("FAIL basic_ch%0d: got sv=%b ch=%0d, want 0 %0d", k, res_v[k], res_ch[k], k);
      end
    end
    total++;
    if ({res_done[0], res_done[1], res_done[2], res_done[3]} !== 4'b0001) begin
      bad++;
      $display("FAIL basic_done: got %b%b%b%b, want 0001",
               res_done[0], res_done[1], res_done[2], res_done[3]);
    end
    total++;
    if (res_busy0 !== 1'b1 || res_busy_end !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy: got after E0=%b after E4=%b, want 1 0", res_busy0, res_busy_end);
    end
    run_scan();
    total++;
    if ({res_v[0], res_v[1], res_v[2], res_v[3]} !== 4'b0000) begin
      bad++;
      $display("FAIL basic_rescan: got sv=%b%b%b%b, want 0000",
               res_v[0], res_v[1], res_v[2], res_v[3]);
    end
  endtask

  task automatic test_off_spike();
    do_reset();
    threshold = 5'd3;
    off_spike_en = 1'b0;
    write_ch(2'd1, 5'd20);
    run_scan();
    settle();
    off_spike_en = 1'b1;
    write_ch(2'd1, 5'd12);
    run_scan();
    total++;
    if (res_v[1] !== 1'b1 || res_ch[1] !== 2'd1 || res_sp[1] !== 2'b11) begin
      bad++;
      $display("FAIL off_spike_en1: got sv=%b ch=%0d sp=%b, want 1 1 11",
               res_v[1], res_ch[1], res_sp[1]);
    end
    settle();
    write_ch(2'd1, 5'd20);
    run_scan();
    settle();
    off_spike_en = 1'b0;
    write_ch(2'd1, 5'd12);
    run_scan();
    total++;
    if (res_v[1] !== 1'b0) begin
      bad++;
      $display("FAIL off_spike_en0: got sv=%b, want 0", res_v[1]);
    end
    // prev must still be 20: rewriting 20 gives diff 0.
    write_ch(2'd1, 5'd20);
    run_scan();
    total++;
    if (res_v[1] !== 1'b0) begin
      bad++;
      $display("FAIL off_prev_kept: got sv=%b, want 0", res_v[1]);
    end
  endtask

  task automatic test_threshold();
    do_reset();
    threshold = 5'd3;
    off_spike_en = 1'b0;
    write_ch(2'd2, 5'd10);
    run_scan();
    settle();
    write_ch(2'd2, 5'd13);
    run_scan();
    total++;
    if (res_v[2] !== 1'b0) begin
      bad++;
      $display("FAIL thr_equal_pos: got sv=%b, want 0", res_v[2]);
    end
    write_ch(2'd2, 5'd14);
    run_scan();
    total++;
    if (res_v[2] !== 1'b1 || res_sp[2] !== 2'b01) begin
      bad++;
      $display("FAIL thr_above: got sv=%b sp=%b, want 1 01", res_v[2], res_sp[2]);
    end
    settle();
    // prev is now 14, so 17 is exactly on the threshold.
    write_ch(2'd2, 5'd17);
    run_scan();
    total++;
    if (res_v[2] !== 1'b0) begin
      bad++;
      $display("FAIL thr_prev_updated: got sv=%b, want 0", res_v[2]);
    end
    off_spike_en = 1'b1;
    write_ch(2'd2, 5'd11);
    run_scan();
    total++;
    if (res_v[2] !== 1'b0) begin
      bad++;
      $display("FAIL thr_equal_neg: got sv=%b, want 0", res_v[2]);
    end
    off_spike_en = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    threshold = 5'd3;
    off_spike_en = 1'b0;
    write_ch(2'd2, 5'd30);
    scan_start = 1'b1;
    tick();
    tick();
    scan_start = 1'b0;
    total++;
    if (busy !== 1'b1 || spike_ch !== 2'd0 || spike_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_e1: got busy=%b ch=%0d sv=%b, want 1 0 0", busy, spike_ch, spike_valid);
    end
    tick();
    ena = 1'b0;
    sample_valid = 1'b1;
    sample_ch = 2'd3;
    sample_data = 5'd31;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (busy !== 1'b1 || spike_valid !== 1'b0 || scan_done !== 1'b0 || spike_ch !== 2'd1) begin
        bad++;
        $display("FAIL stall_hold cyc%0d: got busy=%b sv=%b done=%b ch=%0d, want 1 0 0 1",
                 i, busy, spike_valid, scan_done, spike_ch);
      end
    end
    // Resume while overwriting ch2 during its own evaluation.
    ena = 1'b1;
    sample_ch = 2'd2;
    sample_data = 5'd0;
    tick();
    sample_valid = 1'b0;
    total++;
    if (spike_valid !== 1'b1 || spike_ch !== 2'd2 || spike !== 2'b01 || scan_done !== 1'b0) begin
      bad++;
      $display("FAIL stall_resume_ch2: got sv=%b ch=%0d sp=%b done=%b, want 1 2 01 0",
               spike_valid, spike_ch, spike, scan_done);
    end
    tick();
    total++;
    if (spike_valid !== 1'b0 || spike_ch !== 2'd3 || scan_done !== 1'b1) begin
      bad++;
      $display("FAIL stall_ch3: got sv=%b ch=%0d done=%b, want 0 3 1", spike_valid, spike_ch, scan_done);
    end
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || scan_done !== 1'b0) begin
      bad++;
      $display("FAIL stall_not_queued: got busy=%b done=%b, want 0 0", busy, scan_done);
    end
    settle();
    off_spike_en = 1'b1;
    run_scan();
    total++;
    if (res_v[2] !== 1'b1 || res_sp[2] !== 2'b11 || res_v[3] !== 1'b0) begin
      bad++;
      $display("FAIL stall_new_data: got ch2 sv=%b sp=%b ch3 sv=%b, want 1 11 0",
               res_v[2], res_sp[2], res_v[3]);
    end
    off_spike_en = 1'b0;
  endtask

  task automatic test_refractory();
    logic       exp_v  [4];
    logic [1:0] exp_sp [4];
    logic [4:0] wr     [4];
    wr = '{5'd31, 5'd0, 5'd31, 5'd0};
`ifdef DELTA_REFRACTORY_EN
    exp_v  = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_sp = '{2'b01, 2'b00, 2'b00, 2'b11};
`else
    exp_v  = '{1'b1, 1'b1, 1'b1, 1'b1};
    exp_sp = '{2'b01, 2'b11, 2'b01, 2'b11};
`endif
    do_reset();
    threshold = 5'd3;
    off_spike_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      write_ch(2'd0, wr[s]);
      run_scan();
      total++;
      if (res_v[0] !== exp_v[s] || (exp_v[s] && res_sp[0] !== exp_sp[s])) begin
        bad++;
        $display("FAIL refrac_scan%0d: got sv=%b sp=%b, want %b %b",
                 s + 1, res_v[0], res_sp[0], exp_v[s], exp_sp[s]);
      end
    end
    off_spike_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_off_spike();
    test_threshold();
    test_stall();
    test_refractory();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
